// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads to
// instruction memory and queues returned words with their PC for decode.
//
// state | meaning
// IDLE  | no transaction; waits for a free FIFO slot and no redirect
// REQ   | imem_req high, address held until ack
// WAIT  | acked, waiting for rvalid to push {rdata, pc}
// DROP  | acked transaction was redirected; its response is discarded
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    input  logic                     redir_valid,
    input  logic [31:0]              redir_pc,
    output logic                     if_valid,
    output logic [31:0]              if_instr,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_pc4,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   txn_pc_q;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic          req_ack;

    assign req_ack = (state_q == S_REQ) && imem_ack;
    assign push    = (state_q == S_WAIT) && imem_rvalid && !redir_valid;
    assign pop     = (count_q != '0) && id_ready && !redir_valid;

    // Occupancy after this cycle's push/pop, before any redirect flush.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir_valid) begin
            fetch_pc_d = {redir_pc[31:2], 2'b00};
        end else if (req_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!redir_valid && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redir_valid) begin
                    state_d = imem_ack ? S_DROP : S_IDLE;
                end else if (imem_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir_valid) begin
                    state_d = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_REQ);
        imem_addr = fetch_pc_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            txn_pc_q   <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (req_ack) begin
                txn_pc_q <= fetch_pc_q;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redir_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]    <= txn_pc_q;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign if_valid   = (count_q != '0);
    assign if_instr   = instr_q[rd_ptr_q];
    assign if_pc      = pc_q[rd_ptr_q];
    assign if_pc4     = pc_q[rd_ptr_q] + 32'd4;
    assign fifo_count = count_q;

endmodule
